// File: rtl/axo_mem_rr_arbiter_if.sv
// axo_mem_bus: simple memory request/response bus. The requester drives re/we/asize/addr/wdata,
// and the responder returns ready/error/rdata.
interface axo_mem_bus #(
    parameter int ALEN = 32,
    parameter int DLEN = 32
);
    logic            re;
    logic            we;
    logic [1:0]      asize;
    logic [ALEN-1:0] addr;
    logic [DLEN-1:0] wdata;
    logic            ready;
    logic            error;
    logic [DLEN-1:0] rdata;

    modport master (
        output re, we, asize, addr, wdata,
        input  ready, error, rdata
    );

    modport slave (
        input  re, we, asize, addr, wdata,
        output ready, error, rdata
    );
endinterface

// File: rtl/axo_mem_rr_arbiter.sv
// axo_mem_rr_arbiter: round-robin sharing of one axo_mem_bus target between PORTS hosts, with zero added latency.
// An optional BUSY watchdog is built when the AXO_ARB_TIMEOUT_EN macro is defined.
module axo_mem_rr_arbiter #(
    parameter int              ALEN         = 32,
    parameter int              DLEN         = 32,
    parameter int              PORTS        = 2,
    parameter int              TIMEOUT      = 64,
    parameter logic [DLEN-1:0] TIMEOUT_CODE = {DLEN{1'b1}},
    localparam int             IDW          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    axo_mem_bus.slave      hosts [PORTS],
    axo_mem_bus.master     target,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e           state_r;
    logic [IDW-1:0]   gnt_r;
    logic [IDW-1:0]   rr_ptr_r;

    logic [PORTS-1:0] req_s;
    logic [PORTS-1:0] re_s;
    logic [PORTS-1:0] we_s;
    logic [1:0]       asize_s [PORTS];
    logic [ALEN-1:0]  addr_s  [PORTS];
    logic [DLEN-1:0]  wdata_s [PORTS];
    logic [PORTS-1:0] h_ready_s;
    logic [PORTS-1:0] h_error_s;
    logic [DLEN-1:0]  h_rdata_s [PORTS];

    logic             route_vld_s;
    logic [IDW-1:0]   route_id_s;
    logic             tmo_hit_s;

    if (TIMEOUT < 1 || PORTS < 1 || $bits(TIMEOUT_CODE) != DLEN) begin : g_param_check
        $error("axo_mem_rr_arbiter: invalid parameter set");
    end

    // Next round-robin start position, wrapping PORTS-1 back to 0.
    function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] p);
        logic [IDW-1:0] r;
        if (int'(p) >= PORTS - 1) begin
            r = '0;
        end else begin
            r = p + 1'b1;
        end
        return r;
    endfunction

    // Requester closest to ptr in circular order (distance 0 = ptr itself).
    function automatic logic [IDW-1:0] rr_pick(input logic [PORTS-1:0] req, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] pick;
        int             best_d;
        int             d;
        pick   = '0;
        best_d = PORTS;
        for (int i = 0; i < PORTS; i++) begin
            d = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + PORTS - int'(ptr));
            if (req[i] && d < best_d) begin
                best_d = d;
                pick   = IDW'(i);
            end
        end
        return pick;
    endfunction

    for (genvar g = 0; g < PORTS; g++) begin : g_host
        assign req_s[g]       = hosts[g].re | hosts[g].we;
        assign re_s[g]        = hosts[g].re;
        assign we_s[g]        = hosts[g].we;
        assign asize_s[g]     = hosts[g].asize;
        assign addr_s[g]      = hosts[g].addr;
        assign wdata_s[g]     = hosts[g].wdata;
        assign hosts[g].ready = h_ready_s[g];
        assign hosts[g].error = h_error_s[g];
        assign hosts[g].rdata = h_rdata_s[g];
    end

    // Decide which host (if any) is routed to the target this cycle.
    always_comb begin
        route_vld_s = 1'b0;
        route_id_s  = '0;
        if (rst) begin
            route_vld_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_s) begin
                        route_vld_s = 1'b1;
                        route_id_s  = rr_pick(req_s, rr_ptr_r);
                    end else begin
                        route_vld_s = 1'b0;
                    end
                end
                ST_BUSY: begin
                    // A granted host that drops its request mid-transfer is simply disconnected.
                    if (req_s[gnt_r]) begin
                        route_vld_s = 1'b1;
                        route_id_s  = gnt_r;
                    end else begin
                        route_vld_s = 1'b0;
                    end
                end
                default: route_vld_s = 1'b0;
            endcase
        end
    end

`ifdef AXO_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_r;

    assign tmo_hit_s = route_vld_s && (state_r == ST_BUSY) && !target.ready &&
                       (tmo_cnt_r == TW'(TIMEOUT - 1));

    // Count BUSY cycles; held at zero while idle so each BUSY entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_IDLE) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Forward the routed host's request to the target.
    always_comb begin
        target.re    = 1'b0;
        target.we    = 1'b0;
        target.asize = 2'b00;
        target.addr  = '0;
        target.wdata = '0;
        if (route_vld_s) begin
            target.re    = re_s[route_id_s] & ~tmo_hit_s;
            target.we    = we_s[route_id_s] & ~tmo_hit_s;
            target.asize = asize_s[route_id_s];
            target.addr  = addr_s[route_id_s];
            target.wdata = wdata_s[route_id_s];
        end else begin
            target.re = 1'b0;
        end
    end

    // Return the target response (or a forced timeout error) to the routed host only.
    always_comb begin
        h_ready_s = '0;
        h_error_s = '0;
        for (int i = 0; i < PORTS; i++) begin
            h_rdata_s[i] = '0;
        end
        if (route_vld_s && tmo_hit_s) begin
            h_ready_s[route_id_s] = 1'b1;
            h_error_s[route_id_s] = 1'b1;
            h_rdata_s[route_id_s] = TIMEOUT_CODE;
        end else if (route_vld_s) begin
            h_ready_s[route_id_s] = target.ready;
            h_error_s[route_id_s] = target.error;
            h_rdata_s[route_id_s] = target.rdata;
        end else begin
            h_ready_s = '0;
        end
    end

    assign grant_valid = route_vld_s;
    assign grant_id    = route_id_s;

    // Arbitration state: hold the grant across wait states, rotate priority on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            gnt_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (route_vld_s && target.ready) begin
                        rr_ptr_r <= ptr_next(route_id_s);
                    end else if (route_vld_s) begin
                        gnt_r   <= route_id_s;
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!route_vld_s) begin
                        state_r <= ST_IDLE;
                    end else if (target.ready || tmo_hit_s) begin
                        rr_ptr_r <= ptr_next(gnt_r);
                        state_r  <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
